// File: rtl/telemetry_frame_decoder_if.sv
// rtl/telemetry_frame_decoder_if.sv - receive byte handshake bundle for telemetry_frame_decoder
// Purpose: groups the UART RX byte stream (data/valid/ready) feeding the decoder.
// Signals:
//   rx_data  [7:0]  received byte (source -> decoder)
//   rx_valid        rx_data valid (source -> decoder)
//   rx_ready        decoder accepts byte this cycle (decoder -> source)
// Modports: master = byte source, slave = decoder.
interface telemetry_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/telemetry_frame_decoder.sv
// rtl/telemetry_frame_decoder.sv - framed telemetry byte parser holding last good field values
// Purpose: parses A5 | ID | DATA_HI | DATA_LO | CHK frames (CHK = ID^HI^LO) from a byte stream,
//   clamps and stores throttle/heading/altitude/speed, flags rejected frames.
// Ports:
//   clk           system clock
//   reset_n       synchronous reset, active-low
//   rx            byte stream (slave modport: rx_data, rx_valid in; rx_ready out)
//   throttle      [6:0]  last good throttle, 0..THR_MAX
//   heading       [8:0]  last good heading, 0..HDG_MAX
//   altitude      [15:0] last good altitude, unclamped
//   speed         [9:0]  last good speed, 0..SPD_MAX
//   field_update  [3:0]  one-cycle pulse, bit = ID of field just written
//   frame_err            one-cycle pulse on a rejected frame
//   err_count     [15:0] saturating rejected-frame count
// Build option: TELEM_ERR_CNT_EN enables err_count; otherwise err_count is tied to 0.
module telemetry_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int THR_MAX        = 100,
  parameter int HDG_MAX        = 359,
  parameter int SPD_MAX        = 999
) (
  input  logic                           clk,
  input  logic                           reset_n,
  telemetry_frame_decoder_if.slave       rx,
  output logic [6:0]                     throttle,
  output logic [8:0]                     heading,
  output logic [15:0]                    altitude,
  output logic [9:0]                     speed,
  output logic [3:0]                     field_update,
  output logic                           frame_err,
  output logic [15:0]                    err_count
);

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_HUNT, S_ID, S_DHI, S_DLO, S_CHK, S_COMMIT} state_t;

  state_t          state, state_next;
  logic            rdy_q;
  logic [1:0]      id_q;
  logic [7:0]      hi_q, lo_q;
  logic [CW-1:0]   cnt;
  logic            accept, waiting, timeout, err_next;
  logic [15:0]     value;

  assign rx.rx_ready = rdy_q;
  assign accept      = rx.rx_valid && rdy_q;
  assign waiting     = (state == S_ID) || (state == S_DHI) || (state == S_DLO) || (state == S_CHK);
  // An accepted byte in the last allowed cycle wins over the timeout.
  assign timeout     = waiting && !accept && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign value       = {hi_q, lo_q};

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_HUNT:   if (accept && rx.rx_data == SYNC) state_next = S_ID;
      S_ID: begin
        if (accept) begin
          if (rx.rx_data[7:2] == 6'd0) begin
            state_next = S_DHI;
          end else if (rx.rx_data != SYNC) begin
            state_next = S_HUNT;
            err_next   = 1'b1;
          end
        end
      end
      S_DHI:    if (accept) state_next = S_DLO;
      S_DLO:    if (accept) state_next = S_CHK;
      S_CHK: begin
        if (accept) begin
          if (rx.rx_data == ({6'd0, id_q} ^ hi_q ^ lo_q)) begin
            state_next = S_COMMIT;
          end else begin
            state_next = S_HUNT;
            err_next   = 1'b1;
          end
        end
      end
      S_COMMIT: state_next = S_HUNT;
      default:  state_next = S_HUNT;
    endcase
    if (timeout) begin
      state_next = S_HUNT;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_HUNT;
      rdy_q        <= 1'b0;
      cnt          <= '0;
      id_q         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      throttle     <= '0;
      heading      <= '0;
      altitude     <= '0;
      speed        <= '0;
      field_update <= '0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      // Registered so ready stays low through the reset cycle and drops exactly for COMMIT.
      rdy_q        <= (state_next != S_COMMIT);
      frame_err    <= err_next;
      field_update <= '0;

      if (accept || !waiting || timeout) cnt <= '0;
      else                               cnt <= cnt + 1'b1;

      if (accept && state == S_ID && rx.rx_data[7:2] == 6'd0) id_q <= rx.rx_data[1:0];
      if (accept && state == S_DHI) hi_q <= rx.rx_data;
      if (accept && state == S_DLO) lo_q <= rx.rx_data;

      if (state == S_COMMIT) begin
        field_update <= 4'b0001 << id_q;
        case (id_q)
          2'd0: throttle <= (value > 16'(THR_MAX)) ? 7'(THR_MAX)  : value[6:0];
          2'd1: heading  <= (value > 16'(HDG_MAX)) ? 9'(HDG_MAX)  : value[8:0];
          2'd2: altitude <= value;
          default: speed <= (value > 16'(SPD_MAX)) ? 10'(SPD_MAX) : value[9:0];
        endcase
      end
    end
  end

`ifdef TELEM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                             err_count <= '0;
    else if (frame_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_telemetry_frame_decoder.sv
// tb/tb_telemetry_frame_decoder.sv - self-checking bench for telemetry_frame_decoder
module tb_telemetry_frame_decoder;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  throttle;
  logic [8:0]  heading;
  logic [15:0] altitude;
  logic [9:0]  speed;
  logic [3:0]  field_update;
  logic        frame_err;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_errp   = 0;
  bit checking = 1'b0;

  telemetry_frame_decoder_if rx_if ();

  telemetry_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx_if.slave),
    .throttle(throttle), .heading(heading), .altitude(altitude), .speed(speed),
    .field_update(field_update), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted bytes into a frame buffer and judges whole frames.
  int       m_thr, m_hdg, m_alt, m_spd, m_fu, m_err, m_ready, m_cnt, m_idle;
  bit       m_commit;
  int       m_val, m_fid;
  byte unsigned fr[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_thr = 0; m_hdg = 0; m_alt = 0; m_spd = 0; m_fu = 0; m_err = 0;
        m_ready = 0; m_cnt = 0; m_idle = 0; m_commit = 0; fr.delete();
      end else begin
        m_fu = 0; m_err = 0;
        if (m_commit) begin
          case (m_fid)
            0: m_thr = (m_val > 100) ? 100 : m_val;
            1: m_hdg = (m_val > 359) ? 359 : m_val;
            2: m_alt = m_val;
            default: m_spd = (m_val > 999) ? 999 : m_val;
          endcase
          m_fu = 1 << m_fid;
          m_commit = 0;
        end else if (rx_if.rx_valid && m_ready != 0) begin
          byte unsigned b;
          b = rx_if.rx_data;
          m_idle = 0;
          if (fr.size() == 0) begin
            if (b == 8'hA5) fr.push_back(b);
          end else if (fr.size() == 1) begin
            if (b < 4) fr.push_back(b);
            else if (b != 8'hA5) begin m_err = 1; fr.delete(); end
          end else if (fr.size() < 4) begin
            fr.push_back(b);
          end else begin
            if (b == (fr[1] ^ fr[2] ^ fr[3])) begin
              m_commit = 1;
              m_fid = fr[1];
              m_val = fr[2] * 256 + fr[3];
            end else m_err = 1;
            fr.delete();
          end
        end else if (fr.size() != 0) begin
          m_idle++;
          if (m_idle == T) begin m_err = 1; fr.delete(); m_idle = 0; end
        end
        m_ready = m_commit ? 0 : 1;
`ifdef TELEM_ERR_CNT_EN
        if (m_err != 0 && m_cnt != 16'hFFFF) m_cnt++;
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("throttle", int'(throttle), m_thr);
        chk("heading", int'(heading), m_hdg);
        chk("altitude", int'(altitude), m_alt);
        chk("speed", int'(speed), m_spd);
        chk("field_update", int'(field_update), m_fu);
        chk("frame_err", int'(frame_err), m_err);
        chk("rx_ready", int'(rx_if.rx_ready), m_ready);
        chk("err_count", int'(err_count), m_cnt);
        chk("err_and_update_exclusive", int'(frame_err && field_update != 0), 0);
        if (frame_err === 1'b1) n_errp++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      if (rx_if.rx_ready) got = 1;
    end
    #1;
    rx_if.rx_valid = 1'b0;
    chk("byte_accepted", int'(got), 1);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] ck);
    send_byte(8'hA5); send_byte(id); send_byte(hi); send_byte(lo); send_byte(ck);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    chk("reset_ready_low", int'(rx_if.rx_ready), 0);
    chk("reset_throttle", int'(throttle), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", int'(rx_if.rx_ready), 1);

    // 1: throttle frame, exact update timing
    send_frame(8'h00, 8'h00, 8'h50, 8'h50);
    chk("t1_commit_no_update", int'(field_update), 0);
    chk("t1_commit_ready_low", int'(rx_if.rx_ready), 0);
    @(posedge clk); #1;
    chk("t1_update_pulse", int'(field_update), 1);
    chk("t1_throttle", int'(throttle), 80);
    @(posedge clk); #1;
    chk("t1_update_single", int'(field_update), 0);

    // 2: heading, altitude, speed
    send_frame(8'h01, 8'h01, 8'h5E, 8'h5E);
    send_frame(8'h02, 8'h20, 8'h16, 8'h34);
    send_frame(8'h03, 8'h00, 8'hFB, 8'hF8);
    idle(3);
    chk("t2_heading", int'(heading), 350);
    chk("t2_altitude", int'(altitude), 8214);
    chk("t2_speed", int'(speed), 251);

    // 3: bad checksum
    e0 = n_errp;
    send_frame(8'h03, 8'h00, 8'h10, 8'h00);
    idle(3);
    chk("t3_err_pulses", n_errp - e0, 1);
    chk("t3_speed_held", int'(speed), 251);

    // 4: clamping is not an error
    e0 = n_errp;
    send_frame(8'h01, 8'h02, 8'h00, 8'h03);
    send_frame(8'h00, 8'h00, 8'hFF, 8'hFF);
    idle(3);
    chk("t4_heading_clamp", int'(heading), 359);
    chk("t4_throttle_clamp", int'(throttle), 100);
    chk("t4_no_err", n_errp - e0, 0);

    // 5: resync in ID, stray bytes in HUNT
    e0 = n_errp;
    send_byte(8'hA5); send_byte(8'hA5);
    send_frame(8'h02, 8'h00, 8'h64, 8'h66);
    send_byte(8'h17); send_byte(8'h00); send_byte(8'hA5);
    idle(3);
    chk("t5_altitude", int'(altitude), 100);
    chk("t5_no_err", n_errp - e0, 0);

    // bad ID byte
    e0 = n_errp;
    send_byte(8'h07);
    idle(2);
    chk("bad_id_err", n_errp - e0, 1);

    // 6: timeout inside a frame
    e0 = n_errp;
    send_byte(8'hA5); send_byte(8'h00);
    idle(T - 2);
    chk("t6_no_early_timeout", n_errp - e0, 0);
    idle(5);
    chk("t6_timeout_err", n_errp - e0, 1);

    // 6b: reset mid-frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_heading", int'(heading), 0);
    chk("t6_reset_ready", int'(rx_if.rx_ready), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h00, 8'h00, 8'h0A, 8'h0A);
    idle(3);
    chk("t6_after_reset_throttle", int'(throttle), 10);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
